demux_stream_nch: RTL and testbench

//  Registered, parametrised N-channel stream demultiplexer with valid/ready handshake.

---
 rtl/demux_stream_nch.sv | 109 ++++++++++
 tb/tb_demux_stream_nch.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_nch.sv
// Registered N-channel stream demultiplexer: each accepted beat lands in a one-deep slot on its channel.
// Optional per-channel accepted-beat counters are built when DEMUX_STREAM_CNT_EN is defined.
module demux_stream_nch #(
  parameter int unsigned     BITS      = 8,
  parameter int unsigned     NCH       = 4,
  parameter int unsigned     SELW      = 2,
  parameter logic [BITS-1:0] OTHERWISE = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [SELW-1:0]     in_sel_i,
  input  logic [BITS-1:0]     in_data_i,
  output logic [NCH-1:0]      out_valid_o,
  input  logic [NCH-1:0]      out_ready_i,
  output logic [NCH*BITS-1:0] out_data_o,
  output logic                sel_err_o,
  input  logic                cnt_clr_i,
  output logic [NCH*16-1:0]   cnt_flat_o
);

  logic [NCH-1:0]  selHit;
  logic [NCH-1:0]  load;
  logic            inReady;
  logic [NCH-1:0]  slotValid_q, slotValid_d;
  logic [BITS-1:0] slotData_q [NCH];
  logic            selErr_q, selErr_d;

  // A select with no matching channel is always ready so stray beats drain instead of stalling.
  always_comb begin
    selHit  = '0;
    inReady = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      selHit[k] = (in_sel_i == SELW'(k));
      if (selHit[k]) begin
        inReady = !slotValid_q[k] | out_ready_i[k];
      end
    end
    load        = selHit & {NCH{in_valid_i & inReady}};
    selErr_d    = in_valid_i & ~|selHit;
    slotValid_d = load | (slotValid_q & ~out_ready_i);
  end

  assign in_ready_o  = inReady;
  assign out_valid_o = slotValid_q;
  assign sel_err_o   = selErr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotValid_q <= '0;
      selErr_q    <= 1'b0;
    end else begin
      slotValid_q <= slotValid_d;
      selErr_q    <= selErr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        slotData_q[k] <= OTHERWISE;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load[k]) begin
          slotData_q[k] <= in_data_i;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : gLane
    assign out_data_o[g*BITS +: BITS] = slotValid_q[g] ? slotData_q[g] : OTHERWISE;
  end

`ifdef DEMUX_STREAM_CNT_EN
  logic [15:0] cnt_q [NCH];
  logic [15:0] cnt_d [NCH];

  // Clear dominates a coinciding accept; the 16-bit add wraps naturally.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      cnt_d[k] = cnt_clr_i ? 16'd0 : cnt_q[k] + 16'(load[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= 16'd0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : gCnt
    assign cnt_flat_o[g*16 +: 16] = cnt_q[g];
  end
`else
  logic unusedCntClr;
  assign unusedCntClr = cnt_clr_i;
  assign cnt_flat_o   = '0;
`endif

endmodule

// File: tb/tb_demux_stream_nch.sv
// Directed bench for demux_stream_nch: a 4-channel instance for routing/back-pressure/streaming
// and a 3-channel instance for out-of-range selects. Counter checks follow DEMUX_STREAM_CNT_EN.
module tb_demux_stream_nch;

  localparam logic [7:0] OTH = 8'hC3;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  logic        inValid, inReady, selErr, cntClr;
  logic [1:0]  inSel;
  logic [7:0]  inData;
  logic [3:0]  outValid, outReady;
  logic [31:0] outData;
  logic [63:0] cntFlat;

  logic        bInValid, bInReady, bSelErr;
  logic [1:0]  bInSel;
  logic [7:0]  bInData;
  logic [2:0]  bOutValid, bOutReady;
  logic [23:0] bOutData;
  logic [47:0] bCntFlat;

  always #5 clk = ~clk;

  demux_stream_nch #(.BITS(8), .NCH(4), .SELW(2), .OTHERWISE(OTH)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(inValid), .in_ready_o(inReady),
    .in_sel_i(inSel), .in_data_i(inData), .out_valid_o(outValid), .out_ready_i(outReady),
    .out_data_o(outData), .sel_err_o(selErr), .cnt_clr_i(cntClr), .cnt_flat_o(cntFlat)
  );

  demux_stream_nch #(.BITS(8), .NCH(3), .SELW(2), .OTHERWISE(OTH)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(bInValid), .in_ready_o(bInReady),
    .in_sel_i(bInSel), .in_data_i(bInData), .out_valid_o(bOutValid), .out_ready_i(bOutReady),
    .out_data_o(bOutData), .sel_err_o(bSelErr), .cnt_clr_i(cntClr), .cnt_flat_o(bCntFlat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [7:0] d);
    inValid = v;
    inSel   = s;
    inData  = d;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00);
    outReady = 4'h0; cntClr = 1'b0;
    bInValid = 1'b0; bInSel = 2'd0; bInData = 8'h00; bOutReady = 3'h0;
    repeat (2) tick();
    checks++; if (outValid !== 4'h0) begin errors++; $display("[TB] FAIL reset_valid got %h expected %h", outValid, 4'h0); end
    checks++; if (outData !== {4{OTH}}) begin errors++; $display("[TB] FAIL reset_data got %h expected %h", outData, {4{OTH}}); end
    checks++; if (selErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_selerr got %b expected 0", selErr); end
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1", inReady); end
    checks++; if (cntFlat !== 64'h0) begin errors++; $display("[TB] FAIL reset_cnt got %h expected 0", cntFlat); end
    checks++; if (bOutData !== {3{OTH}}) begin errors++; $display("[TB] FAIL reset_b_data got %h expected %h", bOutData, {3{OTH}}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_route();
    outReady = 4'hF;
    applyStimulus(1'b1, 2'd2, 8'hA5);
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL route_ready got %b expected 1", inReady); end
    tick();
    applyStimulus(1'b0, 2'd1, 8'hFF);
    checks++; if (outValid !== 4'b0100) begin errors++; $display("[TB] FAIL route_valid got %b expected 0100", outValid); end
    checks++; if (outData !== {OTH, 8'hA5, OTH, OTH}) begin errors++; $display("[TB] FAIL route_data got %h expected %h", outData, {OTH, 8'hA5, OTH, OTH}); end
    tick();
    checks++; if (outValid !== 4'b0000) begin errors++; $display("[TB] FAIL route_pop got %b expected 0000", outValid); end
  endtask

  task automatic test_backpressure();
    outReady = 4'b1101;
    applyStimulus(1'b1, 2'd1, 8'h11);
    tick();
    applyStimulus(1'b1, 2'd1, 8'h22);
    checks++; if (inReady !== 1'b0) begin errors++; $display("[TB] FAIL bp_blocked got %b expected 0", inReady); end
    tick();
    checks++; if (outData[8 +: 8] !== 8'h11) begin errors++; $display("[TB] FAIL bp_hold got %h expected 11", outData[8 +: 8]); end
    applyStimulus(1'b1, 2'd3, 8'h33);
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_other_ready got %b expected 1", inReady); end
    tick();
    checks++; if (outValid !== 4'b1010) begin errors++; $display("[TB] FAIL bp_valid got %b expected 1010", outValid); end
    checks++; if (outData !== {8'h33, OTH, 8'h11, OTH}) begin errors++; $display("[TB] FAIL bp_data got %h expected %h", outData, {8'h33, OTH, 8'h11, OTH}); end
    outReady = 4'hF;
    applyStimulus(1'b1, 2'd1, 8'h22);
    checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %b expected 1", inReady); end
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00);
    checks++; if (outValid !== 4'b0010) begin errors++; $display("[TB] FAIL bp_swap_valid got %b expected 0010", outValid); end
    checks++; if (outData[8 +: 8] !== 8'h22) begin errors++; $display("[TB] FAIL bp_swap_data got %h expected 22", outData[8 +: 8]); end
    tick();
  endtask

  task automatic test_back_to_back();
    outReady = 4'hF;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'd0, 8'h40 + 8'(i));
      checks++; if (inReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready[%0d] got %b expected 1", i, inReady); end
      tick();
      checks++; if (outValid[0] !== 1'b1 || outData[7:0] !== 8'h40 + 8'(i)) begin errors++; $display("[TB] FAIL b2b_beat[%0d] got v=%b d=%h expected v=1 d=%h", i, outValid[0], outData[7:0], 8'h40 + 8'(i)); end
    end
    applyStimulus(1'b0, 2'd0, 8'h00);
    tick();
    checks++; if (outValid !== 4'h0) begin errors++; $display("[TB] FAIL b2b_drain got %b expected 0000", outValid); end
  endtask

  task automatic test_reset_mid();
    outReady = 4'h0;
    applyStimulus(1'b1, 2'd0, 8'h99);
    tick();
    applyStimulus(1'b1, 2'd2, 8'h42);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00);
    checks++; if (outValid !== 4'b0101) begin errors++; $display("[TB] FAIL mid_loaded got %b expected 0101", outValid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (outValid !== 4'h0 || outData !== {4{OTH}}) begin errors++; $display("[TB] FAIL mid_async got v=%b d=%h expected v=0 d=%h", outValid, outData, {4{OTH}}); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (outValid !== 4'h0) begin errors++; $display("[TB] FAIL mid_after got %b expected 0000", outValid); end
  endtask

  task automatic test_sel_err();
    bOutReady = 3'b111;
    bInValid = 1'b1; bInSel = 2'd3; bInData = 8'h77;
    #1;
    checks++; if (bInReady !== 1'b1) begin errors++; $display("[TB] FAIL selerr_ready got %b expected 1", bInReady); end
    tick();
    bInValid = 1'b1; bInSel = 2'd2; bInData = 8'h5E;
    checks++; if (bSelErr !== 1'b1) begin errors++; $display("[TB] FAIL selerr_pulse got %b expected 1", bSelErr); end
    checks++; if (bOutValid !== 3'b000) begin errors++; $display("[TB] FAIL selerr_novalid got %b expected 000", bOutValid); end
    tick();
    bInValid = 1'b0; bInSel = 2'd3;
    checks++; if (bSelErr !== 1'b0) begin errors++; $display("[TB] FAIL selerr_once got %b expected 0", bSelErr); end
    checks++; if (bOutValid !== 3'b100 || bOutData !== {8'h5E, OTH, OTH}) begin errors++; $display("[TB] FAIL selerr_inrange got v=%b d=%h expected v=100 d=%h", bOutValid, bOutData, {8'h5E, OTH, OTH}); end
    tick();
    checks++; if (bSelErr !== 1'b0) begin errors++; $display("[TB] FAIL selerr_idle got %b expected 0", bSelErr); end
  endtask

  task automatic test_counters();
`ifdef DEMUX_STREAM_CNT_EN
    checks++; if (bCntFlat !== 48'h0001_0000_0000) begin errors++; $display("[TB] FAIL cnt_b got %h expected %h", bCntFlat, 48'h0001_0000_0000); end
    cntClr = 1'b1;
    tick();
    cntClr = 1'b0;
    checks++; if (cntFlat !== 64'h0) begin errors++; $display("[TB] FAIL cnt_clr got %h expected 0", cntFlat); end
    outReady = 4'hF;
    applyStimulus(1'b1, 2'd0, 8'h01);
    repeat (65535) tick();
    checks++; if (cntFlat[15:0] !== 16'hFFFF) begin errors++; $display("[TB] FAIL cnt_full got %h expected FFFF", cntFlat[15:0]); end
    tick();
    checks++; if (cntFlat[15:0] !== 16'h0000) begin errors++; $display("[TB] FAIL cnt_wrap got %h expected 0000", cntFlat[15:0]); end
    applyStimulus(1'b1, 2'd1, 8'h02);
    repeat (2) tick();
    checks++; if (cntFlat[31:16] !== 16'd2) begin errors++; $display("[TB] FAIL cnt_ch1 got %h expected 0002", cntFlat[31:16]); end
    cntClr = 1'b1;
    tick();
    cntClr = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00);
    checks++; if (cntFlat !== 64'h0) begin errors++; $display("[TB] FAIL cnt_clr_wins got %h expected 0", cntFlat); end
`else
    outReady = 4'hF;
    cntClr = 1'b1;
    applyStimulus(1'b1, 2'd3, 8'h0F);
    tick();
    cntClr = 1'b0;
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00);
    checks++; if (cntFlat !== 64'h0) begin errors++; $display("[TB] FAIL cnt_off got %h expected 0", cntFlat); end
    checks++; if (bCntFlat !== 48'h0) begin errors++; $display("[TB] FAIL cnt_off_b got %h expected 0", bCntFlat); end
`endif
  endtask

  initial begin
    $display("[TB] starting demux_stream_nch bench");
    test_reset();
    test_route();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sel_err();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
